main_sort_pp: RTL and testbench

//  Parametrised successor of the packet sorter: takes Avalon-ST packets on snk, sorts the words of each packet,

---
 rtl/main_sort_pp.sv | 204 ++++++++++++++++++++
 tb/tb_main_sort_pp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/main_sort_pp.sv
// main_sort_pp -- packet sorter with Avalon-ST sink and source.
//   Words of each snk packet are insertion-sorted into an array as they
//   arrive, one per clock. After the packet's EOP they are sent on src as one
//   sorted packet. Sort order (DESCENDING), key signedness (SIGNED_CMP) and
//   depth (MAX_PKT_LEN) are parameters. Words with equal keys stay in arrival
//   order. Words past MAX_PKT_LEN are accepted and dropped.
// Ports:
//   clk_i, srst_i                 clock, synchronous active-high reset
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i, snk_ready_o
//                                 input stream
//   src_data_o/_startofpacket_o/_endofpacket_o/_valid_o, src_ready_i
//                                 sorted output stream, all outputs registered
//   err_o                         only when SORT_ERR_EN is defined. One-clock
//                                 pulse after the EOP transfer of a truncated
//                                 packet, or after a restart caused by SOP in LOAD.
// Macro: SORT_ERR_EN enables err_o and the oversize flag behind it.
module main_sort_pp #(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16,
    parameter int DESCENDING  = 0,
    parameter int SIGNED_CMP  = 0
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
`ifdef SORT_ERR_EN
    ,
    output logic              err_o
`endif
);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int IW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
    logic [DWIDTH-1:0] mem_d [MAX_PKT_LEN];
    logic [DWIDTH-1:0] ins_mem [MAX_PKT_LEN];
    logic [MAX_PKT_LEN-1:0] aft;
    logic [CW-1:0]     cnt_q, cnt_d, rd_q, rd_d;
    logic              ready_q, ready_d, valid_q, valid_d;
    logic              sop_q, sop_d, eop_q, eop_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              snk_xfer, src_xfer;
`ifdef SORT_ERR_EN
    logic              ovf_q, ovf_d, err_q, err_d;
`endif

    // True when key a is placed strictly after key b in the output order.
    function automatic logic is_after(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        logic gt, lt;
        if (SIGNED_CMP != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return (DESCENDING != 0) ? lt : gt;
    endfunction

    // Array as it looks after inserting snk_data_i. Since mem is sorted, aft
    // is a run of 0s followed by 1s over the valid entries; the first 1 marks
    // the insertion point, and everything from there moves up one slot.
    always_comb begin
        for (int j = 0; j < MAX_PKT_LEN; j++)
            aft[j] = (CW'(j) < cnt_q) && is_after(mem_q[j], snk_data_i);
        ins_mem[0] = aft[0] ? snk_data_i : ((cnt_q != '0) ? mem_q[0] : snk_data_i);
        for (int j = 1; j < MAX_PKT_LEN; j++) begin
            if ((CW'(j) < cnt_q) && !aft[j]) ins_mem[j] = mem_q[j];
            else if (aft[j-1])               ins_mem[j] = mem_q[j-1];
            else                             ins_mem[j] = snk_data_i;
        end
    end

    assign snk_xfer = snk_valid_i & ready_q;
    assign src_xfer = valid_q & src_ready_i;

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        ready_d = ready_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
`ifdef SORT_ERR_EN
        ovf_d   = ovf_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (snk_xfer) begin
                    if (snk_startofpacket_i) begin
                        // SOP always (re)starts a packet with this word.
                        mem_d[0] = snk_data_i;
                        cnt_d    = CW'(1);
                        state_d  = S_LOAD;
`ifdef SORT_ERR_EN
                        ovf_d    = 1'b0;
                        err_d    = (state_q == S_LOAD);
`endif
                    end else if (state_q == S_LOAD) begin
                        if (cnt_q != CW'(MAX_PKT_LEN)) begin
                            mem_d = ins_mem;
                            cnt_d = cnt_q + CW'(1);
                        end
`ifdef SORT_ERR_EN
                        else ovf_d = 1'b1;
`endif
                    end
                    // A stray EOP without SOP in IDLE is ignored like its word.
                    if (snk_endofpacket_i && (snk_startofpacket_i || state_q == S_LOAD)) begin
                        state_d = S_DRAIN;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        rd_d    = '0;
                        sop_d   = 1'b1;
                        eop_d   = (cnt_d == CW'(1));
                        data_d  = mem_d[0];
                    end
                end
            end
            S_DRAIN: begin
                if (src_xfer) begin
                    if (eop_q) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        data_d  = '0;
                        cnt_d   = '0;
                        rd_d    = '0;
`ifdef SORT_ERR_EN
                        err_d   = ovf_q;
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        rd_d   = rd_q + CW'(1);
                        data_d = mem_q[rd_d[IW-1:0]];
                        sop_d  = 1'b0;
                        eop_d  = (rd_d == cnt_q - CW'(1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= S_IDLE;
            for (int j = 0; j < MAX_PKT_LEN; j++) mem_q[j] <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
`ifdef SORT_ERR_EN
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
`ifdef SORT_ERR_EN
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`endif
        end
    end

    assign snk_ready_o         = ready_q;
    assign src_valid_o         = valid_q;
    assign src_data_o          = data_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
`ifdef SORT_ERR_EN
    assign err_o               = err_q;
`endif

endmodule

// File: tb/tb_main_sort_pp.sv
// Bench for main_sort_pp: three instances (ascending/unsigned depth 16,
// descending/signed depth 16, ascending/unsigned depth 4) share one snk
// stream and one src_ready. Each instance's output is compared with a
// stable selection-sort reference of the words after the last SOP.
module tb_main_sort_pp;
    localparam int N = 3;
    localparam int MAXL [N] = '{16, 16, 4};
    localparam int DSC  [N] = '{0, 1, 0};
    localparam int SGN  [N] = '{0, 1, 0};

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] snk_data = '0;
    logic snk_sop = 1'b0, snk_eop = 1'b0, snk_vld = 1'b0, src_rdy = 1'b1;
    logic [N-1:0] snk_rdy, vld, sop, eop;
    logic [N-1:0][7:0] dat;
`ifdef SORT_ERR_EN
    logic [N-1:0] err;
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        main_sort_pp #(.DWIDTH(8), .MAX_PKT_LEN(MAXL[g]), .DESCENDING(DSC[g]), .SIGNED_CMP(SGN[g])) u_dut (
            .clk_i(clk), .srst_i(srst),
            .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
            .snk_valid_i(snk_vld), .snk_ready_o(snk_rdy[g]),
            .src_data_o(dat[g]), .src_startofpacket_o(sop[g]), .src_endofpacket_o(eop[g]),
            .src_valid_o(vld[g]), .src_ready_i(src_rdy)
`ifdef SORT_ERR_EN
            , .err_o(err[g])
`endif
        );
    end

    int nchk = 0, nerr = 0;
    bit mon_en = 1'b0;
    bit rmode = 1'b0;
    int rx_idx [N];
    int vcyc [N];
    bit prv_stall [N];
    logic [9:0] prv [N];
    logic [7:0] exp_q [N][$];

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, k, got, exp, $time);
        end
    endtask

    function automatic int key_of(input logic [7:0] x, input int k);
        int v;
        v = (SGN[k] != 0) ? int'($signed(x)) : int'({24'd0, x});
        return (DSC[k] != 0) ? -v : v;
    endfunction

    // Keep the first MAXL words, then repeatedly pull out the earliest word
    // with the smallest key: a stable sort in the requested order.
    function automatic void model(input logic [7:0] w [$], input int k);
        logic [7:0] src [$];
        int best;
        exp_q[k].delete();
        for (int i = 0; i < w.size() && i < MAXL[k]; i++) src.push_back(w[i]);
        while (src.size() > 0) begin
            best = 0;
            for (int i = 1; i < src.size(); i++)
                if (key_of(src[i], k) < key_of(src[best], k)) best = i;
            exp_q[k].push_back(src[best]);
            src.delete(best);
        end
    endfunction

    // src_ready changes just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1 src_rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor.
    initial forever begin
        @(negedge clk);
        if (mon_en && !srst) begin
            for (int k = 0; k < N; k++) begin
                chk("rdy_vs_vld", k, 32'(snk_rdy[k]), 32'(!vld[k]));
                if (vld[k]) begin
                    if (prv_stall[k]) chk("stall_hold", k, 32'({sop[k], eop[k], dat[k]}), 32'(prv[k]));
                    chk("sop", k, 32'(sop[k]), 32'(rx_idx[k] == 0));
                    chk("eop", k, 32'(eop[k]), 32'(rx_idx[k] == exp_q[k].size() - 1));
                    vcyc[k]++;
                    if (src_rdy) begin
                        if (rx_idx[k] < exp_q[k].size()) chk("data", k, 32'(dat[k]), 32'(exp_q[k][rx_idx[k]]));
                        else chk("extra_word", k, 32'(1), 32'(0));
                        rx_idx[k]++;
                    end
                    prv_stall[k] = !src_rdy;
                    prv[k] = {sop[k], eop[k], dat[k]};
                end else begin
                    prv_stall[k] = 1'b0;
                end
            end
        end
    end

    task automatic beat(input logic [7:0] d, input bit s, input bit e);
        snk_data = d; snk_sop = s; snk_eop = e; snk_vld = 1'b1;
        @(posedge clk);
        #1;
        snk_vld = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    endtask

    // garb: non-SOP words sent in IDLE first; rst_len: a discarded SOP prefix.
    task automatic start_pkt(input logic [7:0] w [$], input int garb, input int rst_len, input bit mode);
        for (int k = 0; k < N; k++) begin
            model(w, k);
            rx_idx[k] = 0;
            vcyc[k] = 0;
        end
        rmode = mode;
        for (int i = 0; i < garb; i++) beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < rst_len; i++) beat(8'($urandom), i == 0, 1'b0);
        for (int i = 0; i < w.size(); i++) beat(w[i], i == 0, i == w.size() - 1);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("lat_vld", k, 32'(vld[k]), 32'(1));
            chk("lat_sop", k, 32'(sop[k]), 32'(1));
        end
    endtask

    task automatic send(input logic [7:0] w [$], input int garb, input int rst_len, input bit mode);
        int t;
        start_pkt(w, garb, rst_len, mode);
        t = 0;
        while (vld != '0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 0, 32'(vld), 32'(0));
        for (int k = 0; k < N; k++) begin
            chk("rx_cnt", k, 32'(rx_idx[k]), 32'(exp_q[k].size()));
            if (!mode) chk("drain_len", k, 32'(vcyc[k]), 32'(exp_q[k].size()));
        end
    endtask

    initial begin
        logic [7:0] w [$];
        int len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_vld", k, 32'(vld[k]), 32'(0));
            chk("rst_rdy", k, 32'(snk_rdy[k]), 32'(1));
            chk("rst_sop", k, 32'(sop[k]), 32'(0));
            chk("rst_eop", k, 32'(eop[k]), 32'(0));
            chk("rst_dat", k, 32'(dat[k]), 32'(0));
        end
        srst = 1'b0;
        mon_en = 1'b1;

        w = '{8'd5, 8'd1, 8'd9, 8'd1};        send(w, 0, 0, 1'b0);
        w = '{8'h80, 8'h7F, 8'h00};           send(w, 0, 0, 1'b0);
        w = '{8'h3C};                         send(w, 0, 0, 1'b0);
        repeat (4) begin
            w.delete();
            for (int i = 0; i < 16; i++) w.push_back(8'($urandom));
            send(w, 0, 0, 1'b1);
        end
        w = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0}; send(w, 0, 0, 1'b0);
        w = '{8'd4, 8'd250, 8'd4, 8'd17, 8'd128}; send(w, 3, 3, 1'b1);

        repeat (20) begin
            w.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                w.push_back(($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom));
            send(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a drain.
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(8'($urandom));
        start_pkt(w, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 srst = 1'b1;
        @(posedge clk);
        #1 srst = 1'b0;
        for (int k = 0; k < N; k++) prv_stall[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("mid_rst_vld", k, 32'(vld[k]), 32'(0));
            chk("mid_rst_rdy", k, 32'(snk_rdy[k]), 32'(1));
        end
        w = '{8'd200, 8'd3, 8'd66}; send(w, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
